uart_tx_fifo_feeder: RTL and testbench

Upstream stage of uart_tx. It buffers bytes from the system side in a 256x8 synchronous FIFO, then drains them one at a time into uart_tx through the uart_en / uart_din / uart_tx_busy handshake. uart_tx detects the rising edge of uart_en through two sync flops and samples uart_din one clock after that edge, so the feeder must:
- hold uart_din stable from the uart_en rise until busy is seen;
- guarantee uart_en is low for at least MIN_LOW clocks before every rise.

---
 rtl/uart_fifo_pkg.sv | 22 ++
 rtl/uart_sync_fifo.sv | 84 ++++++++
 rtl/uart_tx_fifo_feeder.sv | 137 +++++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types and defaults for the UART transmit feeder and its FIFO.
package uart_fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 256;
  localparam int FIFO_AW    = 8;
  localparam int FIFO_CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ASSERT    = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Clocks spent in GAP; at least one so the state is never skipped.
  function automatic int gap_clocks(input int min_low);
    return (min_low > 1) ? (min_low - 1) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered read port and registered status flags.
module uart_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic          full_reg;
  logic          empty_reg;
  logic [DW-1:0] rd_data_reg;
  logic          push_ok;
  logic          pop_ok;

  // Status flags are registered, so acceptance decisions use the current count.
  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage write; no reset so the array maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Registered read: popped byte appears the clock after the pop.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_data_reg <= '0;
    end else if (pop_ok) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers wrap naturally at DEPTH; flags track the post-edge count.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign rd_data = rd_data_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign count   = count_reg;

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Buffers system bytes and hands them to uart_tx over the en/din/busy handshake.
module uart_tx_fifo_feeder
  import uart_fifo_pkg::*;
#(
  parameter int DW          = FIFO_DW,
  parameter int DEPTH       = FIFO_DEPTH,
  parameter int AW          = FIFO_AW,
  parameter int ACK_TIMEOUT = 64,
  parameter int MIN_LOW     = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic          ack_timeout,
  input  logic          clr_err,
  input  logic          uart_tx_busy,
  output logic          uart_en,
  output logic [DW-1:0] uart_din,
  output logic          tx_done
);

  localparam int GAP_CLKS = gap_clocks(MIN_LOW);
  localparam int GW       = $clog2(GAP_CLKS + 1);
  localparam int TW       = $clog2(ACK_TIMEOUT + 1);

  state_t        state_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic          uart_en_reg;
  logic [DW-1:0] uart_din_reg;
  logic          tx_done_reg;
  logic          overflow_reg;
  logic          ack_timeout_reg;
  logic          fifo_pop;
  logic [DW-1:0] fifo_rd_data;

  // The FSM pops straight from IDLE; the byte is ready by FETCH.
  assign fifo_pop = (state_reg == IDLE) && !fifo_empty;

  uart_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Sticky overflow: a rejected push sets it, and setting beats clearing.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_en && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (clr_err) begin
      overflow_reg <= 1'b0;
    end
  end

  // Handshake FSM; reset lands in GAP so uart_en stays low before the first rise.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg       <= GAP;
      gap_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      uart_en_reg     <= 1'b0;
      uart_din_reg    <= '0;
      tx_done_reg     <= 1'b0;
      ack_timeout_reg <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      if (clr_err) ack_timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) state_reg <= FETCH;
        end
        FETCH: begin
          uart_din_reg <= fifo_rd_data;
          uart_en_reg  <= 1'b1;
          to_cnt_reg   <= '0;
          state_reg    <= ASSERT;
        end
        ASSERT: begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
          if (uart_tx_busy) begin
            uart_en_reg <= 1'b0;
            state_reg   <= WAIT_DONE;
          end else if (to_cnt_reg == TW'(ACK_TIMEOUT - 1)) begin
            // uart_tx never answered: drop this byte and move on.
            uart_en_reg     <= 1'b0;
            ack_timeout_reg <= 1'b1;
            gap_cnt_reg     <= '0;
            state_reg       <= GAP;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            tx_done_reg <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_reg == GW'(GAP_CLKS - 1)) begin
            gap_cnt_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          uart_en_reg <= 1'b0;
          gap_cnt_reg <= '0;
          state_reg   <= GAP;
        end
      endcase
    end
  end

  assign uart_en     = uart_en_reg;
  assign uart_din    = uart_din_reg;
  assign tx_done     = tx_done_reg;
  assign overflow    = overflow_reg;
  assign ack_timeout = ack_timeout_reg;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder with a behavioural uart_tx and a byte scoreboard.
module tb_uart_tx_fifo_feeder;

  localparam int MIN_LOW = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_err = 1'b0;
  logic       uart_tx_busy;
  logic       fifo_full, fifo_empty, overflow, ack_timeout, uart_en, tx_done;
  logic [8:0] fifo_count;
  logic [7:0] uart_din;

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  // uart_tx model state: mode 0 = model, 1 = busy forced high, 2 = busy tied low
  int   mode = 0;
  int   busy_len = 160;
  logic m_busy = 1'b0;
  int   bcnt = 0;
  logic s1 = 1'b0, s2 = 1'b0;

  // handshake monitor state
  logic       en_prev = 1'b0;
  int         low_cnt = 0;
  logic [7:0] din_at_rise = 8'h00;
  int         rise_cnt = 0;
  int         done_cnt = 0;
  int         peak = 0;

  assign uart_tx_busy = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : m_busy;

  uart_tx_fifo_feeder dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .ack_timeout  (ack_timeout),
    .clr_err      (clr_err),
    .uart_tx_busy (uart_tx_busy),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .tx_done      (tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor and uart_tx model, evaluated on the falling edge.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      low_cnt = 0;
      en_prev = 1'b0;
    end else begin
      if (uart_en && !en_prev) begin
        chk("en_low_before_rise", (low_cnt >= MIN_LOW), 1);
        din_at_rise = uart_din;
        rise_cnt++;
      end
      if (!uart_en && en_prev) chk("din_held_while_en", uart_din, din_at_rise);
      low_cnt = uart_en ? 0 : low_cnt + 1;
      en_prev = uart_en;
      if (tx_done) done_cnt++;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    if (m_busy) begin
      bcnt--;
      if (bcnt <= 0) m_busy = 1'b0;
    end else if (mode == 0 && s1 && !s2) begin
      m_busy = 1'b1;
      bcnt = busy_len;
      chk("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) chk("frame_byte", uart_din, sb.pop_front());
    end
    s2 = s1;
    s1 = uart_en;
  end

  task automatic push(input logic [7:0] d, input bit track);
    @(negedge sys_clk);
    wr_en = 1'b1;
    wr_data = d;
    if (track) sb.push_back(d);
  endtask

  task automatic wr_off();
    @(negedge sys_clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge sys_clk);
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int i;
    i = 0;
    while (i < budget && !(sb.size() == 0 && fifo_empty && !uart_tx_busy && !uart_en)) begin
      @(negedge sys_clk);
      i++;
    end
    chk({tag, "_drain_in_time"}, (i < budget), 1);
    repeat (4) @(negedge sys_clk);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_empty"}, fifo_empty, 1);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_ack_timeout"}, ack_timeout, 0);
    chk({tag, "_uart_en"}, uart_en, 0);
    chk({tag, "_uart_din"}, uart_din, 0);
    chk({tag, "_tx_done"}, tx_done, 0);
  endtask

  initial begin
    int hi;
    int r0;
    int d0;
    int i;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk_reset_state("reset");
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    // Single byte: latency, hold and one tx_done
    busy_len = 160;
    d0 = done_cnt;
    push(8'hA5, 1'b1);
    wr_off();
    chk("single_count_e0", fifo_count, 1);
    chk("single_en_e0", uart_en, 0);
    @(negedge sys_clk);
    chk("single_en_e1", uart_en, 0);
    chk("single_empty_e1", fifo_empty, 1);
    @(negedge sys_clk);
    chk("single_en_e2", uart_en, 1);
    chk("single_din_e2", uart_din, 8'hA5);
    wait_drain(400, "single");
    chk("single_tx_done_pulses", done_cnt - d0, 1);
    chk("single_empty_end", fifo_empty, 1);

    // Burst of 16 in order
    peak = 0;
    r0 = rise_cnt;
    for (int k = 0; k < 16; k++) push(8'(k), 1'b1);
    wr_off();
    wait_drain(3500, "burst");
    chk("burst_peak_15_or_16", (peak == 15 || peak == 16), 1);
    chk("burst_rises", rise_cnt - r0, 16);

    // Push and pop in the same clock at count 1
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    chk("pp_count_after_push", fifo_count, 1);
    wr_off();
    chk("pp_count_push_pop", fifo_count, 1);
    wait_drain(600, "pp");

    // Ack timeout: busy tied low, first byte dropped, second goes through
    mode = 2;
    push(8'h3C, 1'b0);
    push(8'h3D, 1'b1);
    wr_off();
    i = 0;
    while (i < 20 && !uart_en) begin
      @(negedge sys_clk);
      i++;
    end
    chk("to_en_rose", uart_en, 1);
    chk("to_din", uart_din, 8'h3C);
    hi = 0;
    while (uart_en && hi < 200) begin
      hi++;
      @(negedge sys_clk);
    end
    chk("to_en_high_clocks", hi, 64);
    chk("to_flag_set", ack_timeout, 1);
    chk("to_byte_consumed", fifo_count, 1);
    mode = 0;
    pulse_clr();
    chk("to_flag_cleared", ack_timeout, 0);
    wait_drain(600, "to_next");

    // Fill with busy forced high, overflow, then drain across the pointer wrap
    mode = 1;
    busy_len = 8;
    for (int k = 0; k < 257; k++) push(8'(k), 1'b1);
    wr_off();
    chk("fill_count", fifo_count, 256);
    chk("fill_full", fifo_full, 1);
    chk("fill_no_overflow", overflow, 0);
    push(8'hEE, 1'b0);
    wr_off();
    chk("ovf_flag", overflow, 1);
    chk("ovf_count_kept", fifo_count, 256);
    pulse_clr();
    chk("ovf_cleared", overflow, 0);
    void'(sb.pop_front());
    mode = 0;
    wait_drain(8000, "wrap");
    chk("wrap_empty", fifo_empty, 1);

    // Reset while waiting for the frame to finish, with 5 bytes queued
    busy_len = 160;
    for (int k = 0; k < 6; k++) push(8'(8'h60 + k), 1'b1);
    wr_off();
    i = 0;
    while (i < 50 && !(uart_tx_busy && !uart_en)) begin
      @(negedge sys_clk);
      i++;
    end
    chk("rst_reached_wait_done", (uart_tx_busy && !uart_en), 1);
    repeat (3) @(negedge sys_clk);
    chk("rst_queued", fifo_count, 5);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_reset_state("midrst");
    sys_rst = 1'b0;
    sb.delete();
    i = 0;
    while (i < 400 && m_busy) begin
      @(negedge sys_clk);
      i++;
    end
    chk("rst_model_idle", m_busy, 0);
    push(8'h5A, 1'b1);
    wr_off();
    wait_drain(400, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
